// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard/redirect/busy inputs and per-stage enable outputs of the pipeline sequencer
interface pipe_stall_ctrl_if #(parameter int CNT_W = 16);
  logic             hazard_i;
  logic             br_taken_i;
  logic             imem_busy_i;
  logic             dmem_busy_i;
  logic             halt_dec_i;
  logic             pc_en_o;
  logic             ifid_en_o;
  logic             ifid_flush_o;
  logic             idex_en_o;
  logic             idex_bubble_o;
  logic             exmem_en_o;
  logic             memwb_en_o;
  logic             halted_o;
  logic             stall_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  modport master (
    output hazard_i, br_taken_i, imem_busy_i, dmem_busy_i, halt_dec_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o,
           exmem_en_o, memwb_en_o, halted_o, stall_err_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  hazard_i, br_taken_i, imem_busy_i, dmem_busy_i, halt_dec_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o,
           exmem_en_o, memwb_en_o, halted_o, stall_err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: five-stage pipeline sequencer producing latch enables, flush/bubble, halt drain and stall statistics
module pipe_stall_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int DR_W = $clog2(DRAIN_CYC + 1);
  localparam int WD_W = $clog2(MAX_STALL + 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t           state_q, state_d;
  logic [DR_W-1:0]  drain_q, drain_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             run, frz, red, hz_sel, halt_sel;
  logic [6:0]       en;
  assign run      = state_q == RUN;
  assign frz      = state_q != HALTED && bus.dmem_busy_i;
  assign red      = state_q != HALTED && !bus.dmem_busy_i && bus.br_taken_i;
  assign hz_sel   = run && !bus.dmem_busy_i && !bus.br_taken_i && !bus.imem_busy_i && bus.hazard_i;
  assign halt_sel = run && !bus.dmem_busy_i && !bus.br_taken_i && !bus.imem_busy_i && !bus.hazard_i && bus.halt_dec_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN:     if (halt_sel) begin
                 state_d = DRAIN;
                 drain_d = DR_W'(DRAIN_CYC - 1);
               end
      DRAIN:   if (red) state_d = RUN;
               else if (!frz) begin
                 state_d = drain_q == '0 ? HALTED : DRAIN;
                 drain_d = drain_q == '0 ? drain_q : drain_q - 1'b1;
               end
      default: state_d = HALTED;
    endcase
    wd_d        = hz_sel ? (wd_q == WD_W'(MAX_STALL) ? wd_q : wd_q + 1'b1)
                : (run && !bus.dmem_busy_i) ? '0 : wd_q;
    err_d       = err_q || wd_d == WD_W'(MAX_STALL);
    stall_cnt_d = hz_sel && !(&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = red && !(&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  // en = {pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb}
  always_comb begin
    en = state_q == HALTED    ? 7'b0000000
       : frz                  ? 7'b0000000
       : red                  ? 7'b1111111
       : state_q == DRAIN     ? 7'b0001111
       : bus.imem_busy_i      ? 7'b0111011
       : bus.hazard_i         ? 7'b0001111
       : bus.halt_dec_i       ? 7'b0001011
       :                        7'b1101011;
  end
  assign {bus.pc_en_o, bus.ifid_en_o, bus.ifid_flush_o, bus.idex_en_o,
          bus.idex_bubble_o, bus.exmem_en_o, bus.memwb_en_o} = en;
  assign bus.halted_o    = state_q == HALTED;
  assign bus.stall_err_o = err_q;
  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed scoreboard bench for the pipeline sequencer, plus a narrow-counter instance for saturation
module tb_pipe_stall_ctrl;
  localparam logic [4:0] BR = 5'b00001, IM = 5'b00010, DM = 5'b00100, HZ = 5'b01000, HT = 5'b10000, NO = 5'b00000;
  localparam logic [6:0] IDLE = 7'b1101011, FRZ = 7'b0000000, RED = 7'b1111111, FB = 7'b0111011,
                         HAZ = 7'b0001111, HLT = 7'b0001011, DRN = 7'b0001111;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic [6:0] exp_q[$];
  logic [6:0] en1;
  pipe_stall_ctrl_if #(.CNT_W(16)) b1();
  pipe_stall_ctrl_if #(.CNT_W(4))  b2();
  pipe_stall_ctrl #(.DRAIN_CYC(3), .MAX_STALL(64), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  pipe_stall_ctrl #(.DRAIN_CYC(3), .MAX_STALL(64), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  always #5 clk = ~clk;
  assign en1 = {b1.pc_en_o, b1.ifid_en_o, b1.ifid_flush_o, b1.idex_en_o, b1.idex_bubble_o, b1.exmem_en_o, b1.memwb_en_o};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic [4:0] s);
    {b1.halt_dec_i, b1.hazard_i, b1.dmem_busy_i, b1.imem_busy_i, b1.br_taken_i} = s;
    {b2.halt_dec_i, b2.hazard_i, b2.dmem_busy_i, b2.imem_busy_i, b2.br_taken_i} = s;
  endtask
  task automatic cyc(input logic [4:0] s, input logic [6:0] e);
    @(negedge clk);
    drive(s);
    exp_q.push_back(e);
    #1;
    chk("enables", en1, exp_q.pop_front());
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse;
    @(negedge clk);
    drive(NO);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
  initial begin
    drive(NO);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall_cnt", b1.stall_cnt_o, 0);
    chk("rst_flush_cnt", b1.flush_cnt_o, 0);
    chk("rst_halted", b1.halted_o, 0);
    chk("rst_stall_err", b1.stall_err_o, 0);
    cyc(NO, IDLE);
    // load-use stall, then branch beating a hazard
    cyc(HZ, HAZ);
    cyc(HZ, HAZ);
    tick;
    chk("loaduse_stall_cnt", b1.stall_cnt_o, 2);
    cyc(HZ | BR, RED);
    tick;
    chk("br_flush_cnt", b1.flush_cnt_o, 1);
    chk("br_stall_cnt", b1.stall_cnt_o, 2);
    cyc(IM, FB);
    cyc(IM | HZ | HT, FB);
    tick;
    chk("fb_stall_cnt", b1.stall_cnt_o, 2);
    chk("fb_halted", b1.halted_o, 0);
    for (int i = 0; i < 3; i++) cyc(DM | HZ, FRZ);
    cyc(DM | BR, FRZ);
    tick;
    chk("frz_stall_cnt", b1.stall_cnt_o, 2);
    chk("frz_flush_cnt", b1.flush_cnt_o, 1);
    cyc(HZ, HAZ);
    tick;
    chk("resume_stall_cnt", b1.stall_cnt_o, 3);
    // halt with plain drain
    cyc(NO, IDLE);
    cyc(HT, HLT);
    cyc(IM, DRN);
    cyc(HZ, DRN);
    cyc(NO, DRN);
    chk("drain_not_halted", b1.halted_o, 0);
    tick;
    chk("halted_4th_edge", b1.halted_o, 1);
    cyc(HZ | BR, FRZ);
    cyc(NO, FRZ);
    tick;
    chk("halted_flush_cnt", b1.flush_cnt_o, 1);
    chk("halted_sticky", b1.halted_o, 1);
    // halt with dmem freeze inside drain
    rst_pulse;
    cyc(HT, HLT);
    cyc(NO, DRN);
    cyc(DM, FRZ);
    cyc(DM, FRZ);
    cyc(NO, DRN);
    tick;
    chk("frz_drain_not_halted", b1.halted_o, 0);
    cyc(NO, DRN);
    tick;
    chk("frz_drain_halted", b1.halted_o, 1);
    // branch during drain cancels the halt
    rst_pulse;
    cyc(HT, HLT);
    cyc(NO, DRN);
    cyc(BR, RED);
    tick;
    chk("drain_br_halted", b1.halted_o, 0);
    chk("drain_br_flush", b1.flush_cnt_o, 1);
    cyc(NO, IDLE);
    // asynchronous reset while draining, checked before the next edge
    cyc(HT, HLT);
    cyc(NO, DRN);
    #1 rst = 1'b1;
    #1;
    chk("arst_halted", b1.halted_o, 0);
    chk("arst_flush_cnt", b1.flush_cnt_o, 0);
    chk("arst_pc_en", b1.pc_en_o, 1);
    chk("arst_enables", en1, IDLE);
    #1 rst = 1'b0;
    // watchdog and narrow-counter saturation
    cyc(NO, IDLE);
    for (int i = 0; i < 64; i++) begin
      cyc(HZ, HAZ);
      if (i == 19) begin
        tick;
        chk("sat_stall_cnt_w4", b2.stall_cnt_o, 15);
        chk("stall_cnt_w16_20", b1.stall_cnt_o, 20);
      end
      if (i == 62) begin
        tick;
        chk("wd_not_yet", b1.stall_err_o, 0);
      end
    end
    tick;
    chk("wd_err_set", b1.stall_err_o, 1);
    chk("stall_cnt_64", b1.stall_cnt_o, 64);
    chk("sat_hold_w4", b2.stall_cnt_o, 15);
    cyc(NO, IDLE);
    cyc(NO, IDLE);
    tick;
    chk("wd_err_sticky", b1.stall_err_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
